pbit_field_accum: RTL and testbench

PBIT_FIELD_ACCUM -- requirements
Module: pbit_field_accum

---
 rtl/pbit_pkg.sv | 23 ++
 rtl/pbit_sat_clip.sv | 24 ++
 rtl/pbit_field_accum.sv | 126 ++++++++++++
 tb/tb_pbit_field_accum.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// Shared definitions for the p-bit local-field accumulator and the p-bit stage:
// FSM state type, field width and default parameter widths.
package pbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } pbit_state_e;

    localparam int FIELD_WIDTH   = 4;
    localparam int DEF_N_TERMS   = 8;
    localparam int DEF_W_WIDTH   = 4;
    localparam int DEF_ACC_WIDTH = 9;

    // Smallest signed width that holds +/-(n*2^(w-1) + 2^(w-1)) without wrap.
    function automatic int acc_width_min(input int n, input int w);
        int worst;
        worst = n * (2 ** (w - 1)) + (2 ** (w - 1));
        return $clog2(worst + 1) + 1;
    endfunction

endpackage

// File: rtl/pbit_sat_clip.sv
// Clamps a signed accumulator value into the signed FIELD_WIDTH range [-8, +7].
// Only instantiated when PBIT_FIELD_SAT_EN is defined.
module pbit_sat_clip
    import pbit_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]   acc_i,
    output logic signed [FIELD_WIDTH-1:0] field_o
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'((2 ** (FIELD_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(-(2 ** (FIELD_WIDTH - 1)));

    always_comb begin
        field_o = acc_i[FIELD_WIDTH-1:0];
        if (acc_i > MAX_V) begin
            field_o = MAX_V[FIELD_WIDTH-1:0];
        end else if (acc_i < MIN_V) begin
            field_o = MIN_V[FIELD_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pbit_field_accum.sv
// Local-field accumulator for one p-bit: h_i + sum_j J_ij*m_j over N_TERMS terms.
// Define PBIT_FIELD_SAT_EN to clamp the field to [-8,+7]; otherwise it wraps to 4 bits.
module pbit_field_accum
    import pbit_pkg::*;
#(
    parameter int N_TERMS   = DEF_N_TERMS,
    parameter int W_WIDTH   = DEF_W_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [W_WIDTH-1:0]     bias,
    input  logic                          term_valid,
    output logic                          term_ready,
    input  logic                          spin_in,
    input  logic signed [W_WIDTH-1:0]     weight,
    output logic signed [FIELD_WIDTH-1:0] field_out,
    output logic                          field_valid,
    input  logic                          field_ready,
    output logic                          busy
);

    localparam logic [3:0] CNT_LAST = 4'(N_TERMS - 1);

    generate
        if (ACC_WIDTH < acc_width_min(N_TERMS, W_WIDTH)) begin : g_acc_width_check
            $error("pbit_field_accum: ACC_WIDTH too small for N_TERMS/W_WIDTH");
        end
        if (N_TERMS < 1 || N_TERMS > 15) begin : g_n_terms_check
            $error("pbit_field_accum: N_TERMS must be in 1..15");
        end
    endgenerate

    pbit_state_e                    state_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic        [3:0]              count_q;
    logic                           start_q;
    logic signed [FIELD_WIDTH-1:0]  field_out_q;
    logic                           field_valid_q;
    logic                           term_ready_q;
    logic                           busy_q;

    logic signed [ACC_WIDTH-1:0]    bias_ext;
    logic signed [ACC_WIDTH-1:0]    weight_ext;
    logic signed [ACC_WIDTH-1:0]    term_val;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [FIELD_WIDTH-1:0]  field_d;

    // Extend before negating so that -(-2^(W-1)) is representable.
    assign bias_ext   = {{(ACC_WIDTH-W_WIDTH){bias[W_WIDTH-1]}}, bias};
    assign weight_ext = {{(ACC_WIDTH-W_WIDTH){weight[W_WIDTH-1]}}, weight};
    assign term_val   = spin_in ? weight_ext : -weight_ext;
    assign acc_d      = acc_q + term_val;

`ifdef PBIT_FIELD_SAT_EN
    pbit_sat_clip #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_clip (
        .acc_i   (acc_d),
        .field_o (field_d)
    );
`else
    assign field_d = acc_d[FIELD_WIDTH-1:0];
`endif

    // start_q marks an accepted start; ACCUM is entered on the following edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            count_q       <= '0;
            start_q       <= 1'b0;
            field_out_q   <= '0;
            field_valid_q <= 1'b0;
            term_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_q) begin
                        state_q      <= ST_ACCUM;
                        start_q      <= 1'b0;
                        term_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (start) begin
                        acc_q   <= bias_ext;
                        count_q <= '0;
                        start_q <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (term_valid) begin
                        acc_q   <= acc_d;
                        count_q <= count_q + 4'd1;
                        if (count_q == CNT_LAST) begin
                            state_q       <= ST_OUT;
                            term_ready_q  <= 1'b0;
                            field_valid_q <= 1'b1;
                            field_out_q   <= field_d;
                        end
                    end
                end
                ST_OUT: begin
                    if (field_ready) begin
                        state_q       <= ST_IDLE;
                        field_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    term_ready_q  <= 1'b0;
                    field_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign term_ready  = term_ready_q;
    assign field_out   = field_out_q;
    assign field_valid = field_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pbit_field_accum.sv
// Bench for pbit_field_accum: cycle-level reference model plus directed cases
// with hand-computed field values; honours PBIT_FIELD_SAT_EN.
module tb_pbit_field_accum;

    localparam int N_T = 8;
`ifdef PBIT_FIELD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic signed [3:0] bias = '0;
    logic              term_valid = 1'b0;
    logic              term_ready;
    logic              spin_in = 1'b0;
    logic signed [3:0] weight = '0;
    logic signed [3:0] field_out;
    logic              field_valid;
    logic              field_ready = 1'b0;
    logic              busy;

    pbit_field_accum #(
        .N_TERMS   (N_T),
        .W_WIDTH   (4),
        .ACC_WIDTH (9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bias        (bias),
        .term_valid  (term_valid),
        .term_ready  (term_ready),
        .spin_in     (spin_in),
        .weight      (weight),
        .field_out   (field_out),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Field reduction straight from the rules: clamp, or 4-bit two's-complement wrap.
    function automatic int reduce(input int x);
        int r;
        if (SAT) begin
            r = (x > 7) ? 7 : ((x < -8) ? -8 : x);
        end else begin
            r = ((x % 16) + 16) % 16;
            if (r > 7) r = r - 16;
        end
        return r;
    endfunction

    // Reference model: phase 0 idle, 1 start taken, 2 collecting terms, 3 result held.
    int m_ph = 0;
    int m_sum = 0;
    int m_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_ph = 0; m_sum = 0; m_cnt = 0;
        end else begin
            case (m_ph)
                0: if (start) begin m_sum = int'(bias); m_cnt = 0; m_ph = 1; end
                1: m_ph = 2;
                2: if (term_valid) begin
                       m_sum = m_sum + (spin_in ? int'(weight) : -int'(weight));
                       m_cnt++;
                       if (m_cnt == N_T) m_ph = 3;
                   end
                3: if (field_ready) m_ph = 0;
                default: m_ph = 0;
            endcase
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_term_ready", int'(term_ready), int'(m_ph == 2));
            chk("model_field_valid", int'(field_valid), int'(m_ph == 3));
            chk("model_busy", int'(busy), int'(m_ph == 2 || m_ph == 3));
            if (m_ph == 3) chk("model_field_out", int'(field_out), reduce(m_sum));
        end
    end

    logic sp [N_T];
    int   wt [N_T];

    task automatic load_same(input logic s, input int w);
        for (int i = 0; i < N_T; i++) begin sp[i] = s; wt[i] = w; end
    endtask

    task automatic run_case(input int bias_v, input bit gaps, input int hold, input bit poke,
                            input int abort, output int fo, output int lat, output int msum);
        int idx, guard, sc;
        bit tv;
        fo = 0; lat = -1; msum = 0;
        @(negedge clk);
        start = 1'b1; bias = 4'(bias_v); sc = cyc;
        @(negedge clk);
        start = 1'b0;
        idx = 0; guard = 0;
        while (idx < N_T && guard < 300 && !(abort > 0 && idx == abort)) begin
            tv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            term_valid = tv; spin_in = sp[idx]; weight = 4'(wt[idx]);
            if (poke) begin start = 1'($urandom_range(0, 1)); bias = 4'($urandom_range(0, 15)); end
            if (tv && term_ready) idx++;
            guard++;
            @(negedge clk);
        end
        term_valid = 1'b0; start = 1'b0;
        if (abort > 0) begin
            chk("abort_terms_taken", idx, abort);
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            chk("abort_field_out_cleared", int'(field_out), 0);
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk("abort_no_valid", int'(field_valid), 0);
                chk("abort_not_busy", int'(busy), 0);
            end
            return;
        end
        chk("terms_all_accepted", idx, N_T);
        guard = 0;
        while (!field_valid && guard < 50) begin @(negedge clk); guard++; end
        chk("valid_seen", int'(field_valid), 1);
        lat = cyc - sc; fo = int'(field_out); msum = m_sum;
        for (int h = 0; h < hold; h++) begin
            if (poke) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_valid", int'(field_valid), 1);
            chk("hold_stable", int'(field_out), fo);
        end
        start = 1'b0; field_ready = 1'b1;
        @(negedge clk);
        field_ready = 1'b0;
        chk("valid_drop", int'(field_valid), 0);
    endtask

    int fo, lat, msum;

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_field_out", int'(field_out), 0);
        chk("rst_field_valid", int'(field_valid), 0);
        chk("rst_term_ready", int'(term_ready), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // bias +1, eight +1 terms: acc 9
        load_same(1'b1, 1);
        run_case(1, 1'b0, 0, 1'b0, 0, fo, lat, msum);
        $display("case34 field_out=%0d latency=%0d sum=%0d", fo, lat, msum);
        chk("c34_sum", msum, 9);
        chk("c34_field", fo, SAT ? 7 : -7);
        chk("c34_latency", lat, 10);

        // bias 0, alternating spins with weight +3: acc 0
        for (int i = 0; i < N_T; i++) begin sp[i] = (i % 2 == 0); wt[i] = 3; end
        run_case(0, 1'b0, 1, 1'b0, 0, fo, lat, msum);
        $display("case35 field_out=%0d latency=%0d sum=%0d", fo, lat, msum);
        chk("c35_field", fo, 0);
        chk("c35_latency", lat, 10);

        // bias -8, eight spin-0 terms of weight -8: acc +56
        load_same(1'b0, -8);
        run_case(-8, 1'b0, 0, 1'b0, 0, fo, lat, msum);
        $display("case36 field_out=%0d latency=%0d sum=%0d", fo, lat, msum);
        chk("c36_sum", msum, 56);
        chk("c36_field", fo, SAT ? 7 : -8);

        // random gaps, stray starts, output held 5 cycles: 3+2+1-4+5-3+6+1+0 = 11
        sp[0] = 1; wt[0] = 2;   sp[1] = 0; wt[1] = -1;
        sp[2] = 1; wt[2] = -4;  sp[3] = 1; wt[3] = 5;
        sp[4] = 0; wt[4] = 3;   sp[5] = 0; wt[5] = -6;
        sp[6] = 1; wt[6] = 1;   sp[7] = 1; wt[7] = 0;
        run_case(3, 1'b1, 5, 1'b1, 0, fo, lat, msum);
        $display("case37 field_out=%0d latency=%0d sum=%0d", fo, lat, msum);
        chk("c37_sum", msum, 11);
        chk("c37_field", fo, SAT ? 7 : -5);

        // reset after the fourth accepted term, then a clean run giving +2
        load_same(1'b1, 1);
        run_case(5, 1'b0, 0, 1'b0, 4, fo, lat, msum);
        $display("case38a aborted after 4 terms");
        load_same(1'b1, 0);
        run_case(2, 1'b0, 0, 1'b0, 0, fo, lat, msum);
        $display("case38b field_out=%0d latency=%0d sum=%0d", fo, lat, msum);
        chk("c38_field", fo, 2);
        chk("c38_latency", lat, 10);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

endmodule
